// File: rtl/int_div_if.sv
// Request/response bundle for the iterative integer divider.
// The ALU drives the request side (master), the divider answers (slave).
interface int_div_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            o_busy;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_a, i_b,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/int_div.sv
// Restoring shift-subtract divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro INT_DIV_EARLY_OUT_EN: finish in one cycle when b==0 or |a|<|b|.
module int_div #(
  parameter int XLEN = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  int_div_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_EARLY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_signed, a_neg, b_neg, b_zero, accept, trial_ok;
  logic [XLEN-1:0] a_mag, b_mag, rem_nx, quo_nx;
  logic [XLEN:0]   rem_shift, trial;

  // Overrides first, then sign fix-up of the unsigned magnitudes.
  function automatic logic [XLEN-1:0] sel_result(
    input logic            is_rem,
    input logic            div_zero,
    input logic            ovf,
    input logic            neg_quo,
    input logic            neg_rem,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem
  );
    logic [XLEN-1:0] res;
    if (is_rem) begin
      if (div_zero)  res = a;
      else if (ovf)  res = '0;
      else           res = neg_rem ? -rem : rem;
    end else begin
      if (div_zero)  res = '1;
      else if (ovf)  res = {1'b1, {(XLEN-1){1'b0}}};
      else           res = neg_quo ? -quo : quo;
    end
    return res;
  endfunction

  assign in_signed = ~bus.i_op[0];
  assign a_neg     = in_signed & bus.i_a[XLEN-1];
  assign b_neg     = in_signed & bus.i_b[XLEN-1];
  assign a_mag     = a_neg ? -bus.i_a : bus.i_a;
  assign b_mag     = b_neg ? -bus.i_b : bus.i_b;
  assign b_zero    = (bus.i_b == '0);
  assign accept    = bus.i_valid && (state_q == S_IDLE || state_q == S_DONE);

  // The dividend sits in quo and is shifted out of its MSB into rem as quotient bits fill in.
  // A set rem_shift MSB already exceeds any 32-bit divisor, so the 33-bit trial cannot go negative then.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign trial_ok  = rem_shift[XLEN] | ~trial[XLEN];
  assign rem_nx    = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_nx    = {quo_q[XLEN-2:0], trial_ok};

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    a_d        = a_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          is_rem_d   = bus.i_op[1];
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = b_zero;
          ovf_d      = in_signed && (bus.i_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_b == '1);
          a_d        = bus.i_a;
          dvs_d      = b_mag;
          rem_d      = '0;
          quo_d      = a_mag;
          count_d    = '0;
          state_d    = S_CALC;
`ifdef INT_DIV_EARLY_OUT_EN
          if (b_zero || (a_mag < b_mag)) begin
            quo_d   = '0;
            rem_d   = a_mag;
            state_d = S_EARLY;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d  = S_DONE;
          result_d = sel_result(is_rem_q, div_zero_q, ovf_q, neg_quo_q, neg_rem_q,
                                a_q, quo_nx, rem_nx);
        end
      end
      S_EARLY: begin
        state_d  = S_DONE;
        result_d = sel_result(is_rem_q, div_zero_q, ovf_q, neg_quo_q, neg_rem_q,
                              a_q, quo_q, rem_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      a_q        <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      a_q        <= a_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
    end
  end

  assign bus.o_busy   = (state_q == S_CALC);
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_int_div.sv
// Scoreboard bench for int_div: expected result and latency are queued at launch and
// compared when o_valid rises; also covers ignored starts, back-to-back and mid-CALC reset.
module tb_int_div;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  int_div_if #(.XLEN(32)) bus ();

  int_div #(.XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)
      r = op[1] ? a : 32'hFFFF_FFFF;
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = op[1] ? 32'd0 : 32'h8000_0000;
    else begin
      case (op)
        OP_DIV:  r = $signed(a) / $signed(b);
        OP_DIVU: r = a / b;
        OP_REM:  r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? 32'd0 - x : x;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    int lat;
    lat = 32;
`ifdef INT_DIV_EARLY_OUT_EN
    if (b == 32'd0 || mag(a, !op[0]) < mag(b, !op[0])) lat = 1;
`endif
    return lat;
  endfunction

  // Called between edges; returns #1 after the accepting edge with i_valid low.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    exp_q.push_back(ref_result(op, a, b));
    lat_q.push_back(ref_latency(op, a, b));
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
  endtask

  // Waits for o_valid counting edges after acceptance (already = edges consumed so far).
  task automatic collect(input string tag, input int already);
    int          edges;
    int          lat;
    logic [31:0] exp;
    edges = already;
    while (!bus.o_valid && edges < MAX_WAIT) begin
      @(posedge clk);
      #1;
      edges++;
    end
    lat = lat_q.pop_front();
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 32'(edges), 32'(lat));
    check({tag, "_result"}, bus.o_result, exp);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    @(negedge clk);
    launch(op, a, b);
    collect(tag, 0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op    = OP_DIV;
    bus.i_a     = '0;
    bus.i_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_result", bus.o_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    run("div_5_0", OP_DIV, 32'd5, 32'd0);
    run("rem_5_0", OP_REM, 32'd5, 32'd0);
    run("divu_5_0", OP_DIVU, 32'd5, 32'd0);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divu_3_10", OP_DIVU, 32'd3, 32'd10);
    run("rem_m3_10", OP_REM, 32'hFFFF_FFFD, 32'd10);
    run("div_min_m2", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFE);
    run("remu_big", OP_REMU, 32'hDEAD_BEEF, 32'h0001_2345);
    run("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // A start request while busy must be ignored; the original op completes on schedule.
    @(negedge clk);
    launch(OP_DIVU, 32'd1000, 32'd10);
    check("ign_busy", {31'd0, bus.o_busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_op    = OP_REMU;
    bus.i_a     = 32'd9;
    bus.i_b     = 32'd4;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    collect("ign_divu_1000_10", 5);
    repeat (3) @(posedge clk);
    #1;
    check("ign_hold_valid", {31'd0, bus.o_valid}, 32'd1);
    check("ign_hold_result", bus.o_result, 32'd100);

    // Back-to-back: new start issued during the DONE cycle.
    collect_b2b();

    // Reset at CALC iteration 10 discards the op; a fresh op then completes normally.
    @(negedge clk);
    launch(OP_DIVU, 32'd12345, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("mid_rst_result", bus.o_result, 32'd0);
    run("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  task automatic collect_b2b();
    run("b2b_first", OP_DIVU, 32'd100, 32'd7);
    launch(OP_REMU, 32'd100, 32'd7);
    check("b2b_valid_drop", {31'd0, bus.o_valid}, 32'd0);
    check("b2b_busy", {31'd0, bus.o_busy}, 32'd1);
    collect("b2b_second", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
